// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit-queue FSM states and the overflow counter width.
package uart_pkg;

  typedef enum logic [1:0] {TXQ_IDLE, TXQ_LAUNCH, TXQ_WAIT} txq_state_e;

  localparam int OVF_CNT_W = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered count/full/empty and a combinational head output.
module uart_sync_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [ADDR_W:0]       count_next;
  logic                  do_push;
  logic                  do_pop;

  // A pop frees the slot this cycle, so a full FIFO may still accept a push alongside it.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (ADDR_W+1)'(1);
      2'b01:   count_next = count - (ADDR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_next;
      full  <= (count_next == (ADDR_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_tx: buffers pushes and launches one byte at a time on newd/din.
// Define UART_TXQ_OVF_CNT_EN to add the saturating ovf_cnt output.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int CLK_FREQ   = 1000000,
  parameter  int BAUD       = 9600,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  newd,
  output logic [DATA_WIDTH-1:0] din,
  input  logic                  done_tx
`ifdef UART_TXQ_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]  ovf_cnt
`endif
);

  localparam int HOLD   = CLK_FREQ / BAUD;
  localparam int HOLD_W = $clog2(HOLD + 1);

  txq_state_e            state, state_next;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_next;
  logic                  newd_next;
  logic [DATA_WIDTH-1:0] din_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  done_q;
  logic                  pop;
  logic                  drop;

  assign pop  = (state == TXQ_IDLE) && !empty;
  assign drop = wr_en && full && !pop;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    newd_next     = newd;
    din_next      = din;
    case (state)
      TXQ_IDLE: begin
        if (!empty) begin
          din_next      = head;
          newd_next     = 1'b1;
          hold_cnt_next = HOLD_W'(HOLD - 1);
          state_next    = TXQ_LAUNCH;
        end
      end
      // newd stays high for HOLD clocks so the slow baud tick inside uart_tx cannot miss it.
      TXQ_LAUNCH: begin
        if (hold_cnt == '0) begin
          newd_next  = 1'b0;
          state_next = TXQ_WAIT;
        end else begin
          hold_cnt_next = hold_cnt - HOLD_W'(1);
        end
      end
      TXQ_WAIT: begin
        if (done_tx && !done_q) state_next = TXQ_IDLE;
      end
      default: state_next = TXQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TXQ_IDLE;
      hold_cnt <= '0;
      newd     <= 1'b0;
      din      <= '0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      newd     <= newd_next;
      din      <= din_next;
      done_q   <= done_tx;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef UART_TXQ_OVF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected launch bytes, a monitor checks each launch.
module tb_uart_tx_queue;

  localparam int HOLD = 104;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       done_tx;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       newd;
  logic [7:0] din;
`ifdef UART_TXQ_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_queue dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .newd     (newd),
    .din      (din),
    .done_tx  (done_tx)
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: each newd rising edge is a launch; its byte must match the scoreboard head.
  initial begin
    logic       prev_newd;
    int         width;
    logic [7:0] launched;
    prev_newd = 1'b0;
    width     = 0;
    launched  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_newd = 1'b0;
        width     = 0;
      end else begin
        if (newd && !prev_newd) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL launch_unexpected actual=%0h required=none", din);
          end else begin
            check("launch_din", din, exp_q.pop_front());
          end
          launched = din;
          width    = 1;
        end else if (newd) begin
          width++;
        end else if (prev_newd) begin
          check("newd_width", width, HOLD);
          check("din_held", din, launched);
        end
        prev_newd = newd;
      end
    end
  end

  task automatic pulse_done();
    @(negedge clk);
    done_tx = 1'b1;
    @(negedge clk);
    done_tx = 1'b0;
  endtask

  task automatic wait_newd(input logic val, input int limit, input string name);
    int n = 0;
    while (newd !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, newd, val);
  endtask

  task automatic burst(input int n, input int n_expected, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      if (i < n_expected) exp_q.push_back(base + 8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    done_tx = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_newd", newd, 0);
    check("rst_din", din, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Single byte: one clock from push to launch.
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check("push_count", count, 1);
    check("push_newd_low", newd, 0);
    @(negedge clk);
    check("launch_latency", newd, 1);
    check("launch_count", count, 0);
    check("launch_empty", empty, 1);

    // done_tx during LAUNCH must be ignored; WAIT holds until a fresh rising edge.
    pulse_done();
    wait_newd(1'b0, 200, "a5_newd_fall");
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (10) @(negedge clk);
    check("wait_holds_newd", newd, 0);
    check("wait_holds_count", count, 1);
    pulse_done();
    @(negedge clk);
    check("relaunch_newd", newd, 1);
    wait_newd(1'b0, 200, "3c_newd_fall");
    pulse_done();
    repeat (2) @(negedge clk);
    check("idle_empty", empty, 1);
    check("idle_newd", newd, 0);

    // 18 back-to-back pushes, done_tx low: 0x00 in flight, 16 stored, 0x11 dropped.
    burst(18, 17, 8'h00);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_overflow", overflow, 1);
    check("fill_inflight", din, 8'h00);

    // Push 0x55 in the same cycle as the pop: accepted while full.
    wait_newd(1'b0, 200, "00_newd_fall");
    @(negedge clk);
    done_tx = 1'b1;
    @(negedge clk);
    done_tx = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    check("poppush_count", count, 16);
    check("poppush_full", full, 1);
    check("poppush_newd", newd, 1);
    check("overflow_sticky", overflow, 1);

    for (int i = 0; i < 17; i++) begin
      wait_newd(1'b1, 10, "drain_rise");
      wait_newd(1'b0, 200, "drain_fall");
      pulse_done();
    end
    repeat (2) @(negedge clk);
    check("drained_empty", empty, 1);
    check("drained_count", count, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of LAUNCH (hold counter at 50).
    burst(3, 3, 8'h77);
    repeat (52) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_newd", newd, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_overflow", overflow, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (newd) seen++;
    end
    check("no_launch_after_reset", seen, 0);
    check("post_rst_empty", empty, 1);

`ifdef UART_TXQ_OVF_CNT_EN
    burst(20, 17, 8'h00);
    check("ovf_cnt_3", ovf_cnt, 3);
    burst(297, 0, 8'hE0);
    check("ovf_cnt_sat", ovf_cnt, 255);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("ovf_cnt_rst", ovf_cnt, 0);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
